// File: rtl/sixbit_minmax_tracker.sv
// Streaming front-end for the 6-bit signed >= comparator: collects FRAME_LEN samples
// and reports the frame maximum and minimum, using the external comparator for every ordering decision.
module sixbit_minmax_tracker #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_data,
  input  logic             flush,
  output logic [5:0]       cmp_x,
  output logic [5:0]       cmp_y,
  input  logic             cmp_agteqb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_max,
  output logic [5:0]       out_min,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);

  typedef enum logic [1:0] {ACCEPT, CMP_MAX, CMP_MIN, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] counter;
  logic [5:0]       sample;
  logic [5:0]       max_q;
  logic [5:0]       min_q;
  logic             frame_full;

  assign frame_full = (counter == FRAME_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ACCEPT;
    else       state <= state_next;
  end

  // flush aborts any partial frame, but a finished result is always delivered
  always_comb begin
    state_next = state;
    unique case (state)
      ACCEPT:  if (flush)         state_next = ACCEPT;
               else if (in_valid) state_next = CMP_MAX;
      CMP_MAX: state_next = flush ? ACCEPT : CMP_MIN;
      CMP_MIN: if (flush)           state_next = ACCEPT;
               else if (frame_full) state_next = DONE;
               else                 state_next = ACCEPT;
      DONE:    if (out_ready) state_next = ACCEPT;
      default: state_next = ACCEPT;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    cmp_x     = 6'h00;
    cmp_y     = 6'h00;
    unique case (state)
      ACCEPT:  in_ready = 1'b1;
      CMP_MAX: begin
        cmp_x = sample;
        cmp_y = max_q;
      end
      CMP_MIN: begin
        cmp_x = min_q;
        cmp_y = sample;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // The result registers take the post-compare minimum directly, since min_q updates on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter   <= '0;
      sample    <= 6'h00;
      max_q     <= 6'h00;
      min_q     <= 6'h00;
      out_max   <= 6'h00;
      out_min   <= 6'h00;
      out_count <= '0;
    end else begin
      unique case (state)
        ACCEPT: begin
          if (flush) begin
            counter <= '0;
          end else if (in_valid) begin
            sample  <= in_data;
            counter <= counter + 1'b1;
            if (counter == '0) begin
              max_q <= in_data;
              min_q <= in_data;
            end
          end
        end
        CMP_MAX: begin
          if (flush)           counter <= '0;
          else if (cmp_agteqb) max_q   <= sample;
        end
        CMP_MIN: begin
          if (flush) begin
            counter <= '0;
          end else begin
            if (cmp_agteqb) min_q <= sample;
            if (frame_full) begin
              out_max   <= max_q;
              out_min   <= cmp_agteqb ? sample : min_q;
              out_count <= FRAME_CNT;
            end
          end
        end
        DONE: begin
          if (out_ready) counter <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
